// File: rtl/usb_desc_reader.sv
// EP0 GET_DESCRIPTOR data-stage sequencer: selects a descriptor from the table,
// clamps it to wLength, and streams it from the ROM as max-packet-size IN packets.
module usb_desc_reader #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_type,
  input  logic [7:0]        req_index,
  input  logic [LEN_W-1:0]  req_wlength,
  input  logic              hs_mode,
  input  logic [6:0]        ep0_mps,
  input  logic              abort,
  input  logic [ADDR_W-1:0] desc_dev_addr_i,
  input  logic [ADDR_W-1:0] desc_dev_len_i,
  input  logic [ADDR_W-1:0] desc_qual_addr_i,
  input  logic [ADDR_W-1:0] desc_qual_len_i,
  input  logic [ADDR_W-1:0] desc_fscfg_addr_i,
  input  logic [ADDR_W-1:0] desc_fscfg_len_i,
  input  logic [ADDR_W-1:0] desc_hscfg_addr_i,
  input  logic [ADDR_W-1:0] desc_hscfg_len_i,
  input  logic [ADDR_W-1:0] desc_hidrpt_addr_i,
  input  logic [ADDR_W-1:0] desc_hidrpt_len_i,
  input  logic [ADDR_W-1:0] desc_bos_addr_i,
  input  logic [ADDR_W-1:0] desc_bos_len_i,
  input  logic [ADDR_W-1:0] desc_strvendor_addr_i,
  input  logic [ADDR_W-1:0] desc_strvendor_len_i,
  input  logic [ADDR_W-1:0] desc_strproduct_addr_i,
  input  logic [ADDR_W-1:0] desc_strproduct_len_i,
  input  logic [ADDR_W-1:0] desc_strserial_addr_i,
  input  logic [ADDR_W-1:0] desc_strserial_len_i,
  input  logic [ADDR_W-1:0] desc_strlang_addr_i,
  input  logic              desc_have_strings_i,
  output logic [ADDR_W-1:0] descrom_raddr_o,
  input  logic [7:0]        descrom_rdata_i,
  input  logic              in_token,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              tx_last,
  output logic              tx_zlp,
  input  logic              tx_ready,
  input  logic              pkt_ack,
  input  logic              pkt_retry,
  output logic              req_stall,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, LOOKUP, WAIT_IN, SEND, WAIT_ACK} state_t;

  state_t            state;
  logic [7:0]        cur_type;
  logic [7:0]        cur_index;
  logic [LEN_W-1:0]  cur_wlength;
  logic              cur_hs;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  offset;
  logic [LEN_W-1:0]  pkt_start;
  logic [LEN_W-1:0]  pkt_len;
  logic [LEN_W-1:0]  pkt_left;
  logic              zlp_needed;
  logic              in_zlp;

  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] sel_len;
  logic              sel_hit;
  logic              sel_ok;
  logic [LEN_W-1:0]  desc_len;
  logic [LEN_W-1:0]  xfer_len;
  logic [LEN_W-1:0]  mps_len;
  logic              zlp_calc;
  logic [LEN_W-1:0]  pkt_len_next;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    sel_hit  = 1'b1;
    case (cur_type)
      8'h01: begin sel_addr = desc_dev_addr_i;    sel_len = desc_dev_len_i;    end
      8'h02: begin
        sel_addr = cur_hs ? desc_hscfg_addr_i : desc_fscfg_addr_i;
        sel_len  = cur_hs ? desc_hscfg_len_i  : desc_fscfg_len_i;
      end
      8'h06: begin sel_addr = desc_qual_addr_i;   sel_len = desc_qual_len_i;   end
      8'h07: begin
        sel_addr = cur_hs ? desc_fscfg_addr_i : desc_hscfg_addr_i;
        sel_len  = cur_hs ? desc_fscfg_len_i  : desc_hscfg_len_i;
      end
      8'h0F: begin sel_addr = desc_bos_addr_i;    sel_len = desc_bos_len_i;    end
      8'h22: begin sel_addr = desc_hidrpt_addr_i; sel_len = desc_hidrpt_len_i; end
      8'h03: begin
        if (!desc_have_strings_i) begin
          sel_hit = 1'b0;
        end else begin
          case (cur_index)
            8'd0: begin sel_addr = desc_strlang_addr_i;    sel_len = ADDR_W'(4);            end
            8'd1: begin sel_addr = desc_strvendor_addr_i;  sel_len = desc_strvendor_len_i;  end
            8'd2: begin sel_addr = desc_strproduct_addr_i; sel_len = desc_strproduct_len_i; end
            8'd3: begin sel_addr = desc_strserial_addr_i;  sel_len = desc_strserial_len_i;  end
            default: sel_hit = 1'b0;
          endcase
        end
      end
      default: sel_hit = 1'b0;
    endcase
  end

  assign sel_ok   = sel_hit && (sel_len != '0);
  assign desc_len = LEN_W'(sel_len);
  assign xfer_len = (desc_len < cur_wlength) ? desc_len : cur_wlength;
  assign mps_len  = LEN_W'(ep0_mps);
  // EP0 max packet size is a power of two, so the modulo reduces to a mask.
  assign zlp_calc = (xfer_len == '0) ||
                    ((desc_len < cur_wlength) && ((xfer_len & (mps_len - LEN_W'(1))) == '0));
  assign pkt_len_next = (remaining < mps_len) ? remaining : mps_len;

  // Byte 1 of an other-speed config must report its own descriptor type.
  assign tx_data   = (cur_type == 8'h07 && offset == LEN_W'(1)) ? 8'h07 : descrom_rdata_i;
  assign busy      = (state != IDLE);
  assign req_ready = (state == IDLE);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cur_type        <= '0;
      cur_index       <= '0;
      cur_wlength     <= '0;
      cur_hs          <= 1'b0;
      base            <= '0;
      remaining       <= '0;
      offset          <= '0;
      pkt_start       <= '0;
      pkt_len         <= '0;
      pkt_left        <= '0;
      zlp_needed      <= 1'b0;
      in_zlp          <= 1'b0;
      descrom_raddr_o <= '0;
      tx_valid        <= 1'b0;
      tx_last         <= 1'b0;
      tx_zlp          <= 1'b0;
      req_stall       <= 1'b0;
      done            <= 1'b0;
    end else begin
      tx_zlp    <= 1'b0;
      req_stall <= 1'b0;
      done      <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        tx_valid <= 1'b0;
        tx_last  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (req_valid) begin
            cur_type    <= req_type;
            cur_index   <= req_index;
            cur_wlength <= req_wlength;
            cur_hs      <= hs_mode;
            state       <= LOOKUP;
          end
          LOOKUP: if (!sel_ok) begin
            req_stall <= 1'b1;
            state     <= IDLE;
          end else begin
            base            <= sel_addr;
            remaining       <= xfer_len;
            zlp_needed      <= zlp_calc;
            offset          <= '0;
            descrom_raddr_o <= sel_addr;
            state           <= WAIT_IN;
          end
          WAIT_IN: if (in_token) begin
            if (remaining != '0) begin
              pkt_start       <= offset;
              pkt_len         <= pkt_len_next;
              pkt_left        <= pkt_len_next;
              descrom_raddr_o <= base + ADDR_W'(offset);
              tx_valid        <= 1'b1;
              tx_last         <= (pkt_len_next == LEN_W'(1));
              in_zlp          <= 1'b0;
              state           <= SEND;
            end else if (zlp_needed) begin
              tx_zlp <= 1'b1;
              in_zlp <= 1'b1;
              state  <= WAIT_ACK;
            end
          end
          SEND: if (tx_ready) begin
            offset          <= offset + LEN_W'(1);
            descrom_raddr_o <= base + ADDR_W'(offset + LEN_W'(1));
            if (tx_last) begin
              tx_valid <= 1'b0;
              tx_last  <= 1'b0;
              state    <= WAIT_ACK;
            end else begin
              pkt_left <= pkt_left - LEN_W'(1);
              tx_last  <= (pkt_left == LEN_W'(2));
            end
          end
          WAIT_ACK: if (pkt_ack) begin
            if (in_zlp) begin
              zlp_needed <= 1'b0;
              done       <= 1'b1;
              state      <= IDLE;
            end else begin
              remaining <= remaining - pkt_len;
              if (remaining == pkt_len && !zlp_needed) begin
                done  <= 1'b1;
                state <= IDLE;
              end else begin
                state <= WAIT_IN;
              end
            end
          end else if (pkt_retry) begin
            if (!in_zlp) offset <= pkt_start;
            state <= WAIT_IN;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_desc_reader.sv
// Self-checking bench for usb_desc_reader: table-driven vectors, hand-written
// abort/reset sequences and randomized requests against a descriptor-level model.
module tb_usb_desc_reader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_ready, hs_mode, abort, in_token;
  logic [7:0]  req_type, req_index, tx_data;
  logic [15:0] req_wlength, descrom_raddr_o;
  logic [6:0]  ep0_mps;
  logic [7:0]  descrom_rdata_i;
  logic        tx_valid, tx_last, tx_zlp, tx_ready, pkt_ack, pkt_retry;
  logic        req_stall, busy, done, have_strings;

  logic [15:0] dev_addr, dev_len, qual_addr, qual_len, fscfg_addr, fscfg_len;
  logic [15:0] hscfg_addr, hscfg_len, hidrpt_addr, hidrpt_len, bos_addr, bos_len;
  logic [15:0] strv_addr, strv_len, strp_addr, strp_len, strs_addr, strs_len, strlang_addr;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    logic [7:0] lo;
    lo = a[7:0] * 8'd3;
    return lo ^ a[15:8] ^ 8'hA5;
  endfunction

  assign descrom_rdata_i = rom_byte(descrom_raddr_o);

  usb_desc_reader dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_index(req_index), .req_wlength(req_wlength),
    .hs_mode(hs_mode), .ep0_mps(ep0_mps), .abort(abort),
    .desc_dev_addr_i(dev_addr), .desc_dev_len_i(dev_len),
    .desc_qual_addr_i(qual_addr), .desc_qual_len_i(qual_len),
    .desc_fscfg_addr_i(fscfg_addr), .desc_fscfg_len_i(fscfg_len),
    .desc_hscfg_addr_i(hscfg_addr), .desc_hscfg_len_i(hscfg_len),
    .desc_hidrpt_addr_i(hidrpt_addr), .desc_hidrpt_len_i(hidrpt_len),
    .desc_bos_addr_i(bos_addr), .desc_bos_len_i(bos_len),
    .desc_strvendor_addr_i(strv_addr), .desc_strvendor_len_i(strv_len),
    .desc_strproduct_addr_i(strp_addr), .desc_strproduct_len_i(strp_len),
    .desc_strserial_addr_i(strs_addr), .desc_strserial_len_i(strs_len),
    .desc_strlang_addr_i(strlang_addr), .desc_have_strings_i(have_strings),
    .descrom_raddr_o(descrom_raddr_o), .descrom_rdata_i(descrom_rdata_i),
    .in_token(in_token), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_zlp(tx_zlp), .tx_ready(tx_ready), .pkt_ack(pkt_ack), .pkt_retry(pkt_retry),
    .req_stall(req_stall), .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Descriptor selection straight from the request rules.
  function automatic void model_sel(input logic [7:0] t, input logic [7:0] idx,
                                    input logic hs_v, input logic hstr,
                                    output logic ok, output logic [15:0] b, output logic [15:0] l);
    ok = 1'b1; b = '0; l = '0;
    case (t)
      8'h01: begin b = dev_addr; l = dev_len; end
      8'h02: begin b = hs_v ? hscfg_addr : fscfg_addr; l = hs_v ? hscfg_len : fscfg_len; end
      8'h06: begin b = qual_addr; l = qual_len; end
      8'h07: begin b = hs_v ? fscfg_addr : hscfg_addr; l = hs_v ? fscfg_len : hscfg_len; end
      8'h0F: begin b = bos_addr; l = bos_len; end
      8'h22: begin b = hidrpt_addr; l = hidrpt_len; end
      8'h03: begin
        if (!hstr || idx > 8'd3) ok = 1'b0;
        else if (idx == 8'd0) begin b = strlang_addr; l = 16'd4; end
        else if (idx == 8'd1) begin b = strv_addr; l = strv_len; end
        else if (idx == 8'd2) begin b = strp_addr; l = strp_len; end
        else begin b = strs_addr; l = strs_len; end
      end
      default: ok = 1'b0;
    endcase
    if (l == 16'd0) ok = 1'b0;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [7:0] t, input logic [15:0] b, input logic [15:0] off);
    logic [15:0] a;
    a = b + off;
    return (t == 8'h07 && off == 16'd1) ? 8'h07 : rom_byte(a);
  endfunction

  // Full request: issue, lookup, then every IN packet with ACK / optional retry.
  task automatic run_xfer(input logic [7:0] t, input logic [7:0] idx, input logic [15:0] wl,
                          input logic hs_v, input logic [6:0] mps, input logic exp_stall,
                          input logic [15:0] exp_base, input logic [15:0] exp_len,
                          input logic exp_zlp, input int retry_pkt, input bit rand_ready);
    logic [15:0] nbytes, pos, plen, ea;
    bit zlp_pend, retried, last;
    int pkt, k, cyc;
    ep0_mps = mps;
    @(negedge clk);
    req_valid = 1'b1; req_type = t; req_index = idx; req_wlength = wl; hs_mode = hs_v;
    @(negedge clk);
    req_valid = 1'b0; req_type = 8'h55; req_index = 8'hAA; req_wlength = 16'hFFFF; hs_mode = ~hs_v;
    check("lookup_busy", busy, 1);
    @(negedge clk);
    check("req_stall", req_stall, exp_stall);
    check("no_tx_after_lookup", tx_valid, 0);
    if (exp_stall) begin
      check("stall_req_ready", req_ready, 1);
      @(negedge clk);
      check("stall_pulse_end", req_stall, 0);
      check("stall_no_done", done, 0);
      return;
    end
    check("wait_in_busy", busy, 1);
    nbytes = (exp_len < wl) ? exp_len : wl;
    zlp_pend = exp_zlp; pos = '0; pkt = 0; retried = 0;
    while ((pos < nbytes || zlp_pend) && pkt < 100) begin
      plen = (pos < nbytes) ? (((nbytes - pos) < 16'(mps)) ? (nbytes - pos) : 16'(mps)) : 16'd0;
      repeat ($urandom_range(0, 2)) begin
        req_valid = 1'($urandom_range(0, 1)); req_type = 8'h01;
        @(negedge clk);
      end
      req_valid = 1'b0;
      in_token = 1'b1;
      @(negedge clk);
      in_token = 1'b0;
      if (plen == 16'd0) begin
        check("tx_zlp", tx_zlp, 1);
        check("zlp_no_valid", tx_valid, 0);
      end else begin
        k = 0; cyc = 0;
        while (k < int'(plen) && cyc < 400) begin
          tx_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
          check("tx_valid", tx_valid, 1);
          if (tx_ready) begin
            ea = exp_base + pos + 16'(k);
            check("raddr", descrom_raddr_o, ea);
            check("tx_data", tx_data, exp_byte(t, exp_base, pos + 16'(k)));
            check("tx_last", tx_last, (k == int'(plen) - 1));
            k++;
          end
          @(negedge clk);
          cyc++;
        end
        tx_ready = 1'b0;
        check("pkt_bytes", k, plen);
        check("valid_after_pkt", tx_valid, 0);
      end
      if (pkt == retry_pkt && !retried) begin
        retried = 1;
        pkt_retry = 1'b1;
        @(negedge clk);
        pkt_retry = 1'b0;
        check("retry_no_done", done, 0);
        check("retry_busy", busy, 1);
      end else begin
        pkt_ack = 1'b1;
        pkt_retry = 1'($urandom_range(0, 1));
        @(negedge clk);
        pkt_ack = 1'b0; pkt_retry = 1'b0;
        if (plen == 16'd0) zlp_pend = 0;
        else pos = pos + plen;
        pkt++;
        last = (pos >= nbytes) && !zlp_pend;
        check("done", done, last);
        check("busy_after_ack", busy, !last);
      end
    end
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  typedef struct {
    logic [7:0]  typ;
    logic [7:0]  idx;
    logic [15:0] wlen;
    logic        hs;
    logic [6:0]  mps;
    logic        have_str;
    logic [15:0] dlen;
    logic [15:0] blen;
    logic        exp_stall;
    logic [15:0] exp_base;
    logic [15:0] exp_len;
    logic        exp_zlp;
    int          retry;
  } vec_t;

  vec_t vecs[16];
  logic [7:0] type_tab[8];
  logic [6:0] mps_tab[4];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic ok, rz;
    logic [15:0] rb, rl, nb;
    logic [7:0] rt, ri;
    logic [15:0] rw;
    logic rh, rs;
    logic [6:0] rm;

    dev_addr = 16'd0;     dev_len = 16'd18;
    qual_addr = 16'd18;   qual_len = 16'd10;
    fscfg_addr = 16'd28;  fscfg_len = 16'd39;
    hscfg_addr = 16'd67;  hscfg_len = 16'd39;
    hidrpt_addr = 16'd106; hidrpt_len = 16'd50;
    strlang_addr = 16'd156;
    strv_addr = 16'd160;  strv_len = 16'd7;
    strp_addr = 16'd167;  strp_len = 16'd38;
    strs_addr = 16'd205;  strs_len = 16'd10;
    bos_addr = 16'd300;   bos_len = 16'd5;
    have_strings = 1'b1;

    rst = 1'b1; req_valid = 0; req_type = 0; req_index = 0; req_wlength = 0; hs_mode = 0;
    ep0_mps = 7'd64; abort = 0; in_token = 0; tx_ready = 0; pkt_ack = 0; pkt_retry = 0;
    repeat (2) @(negedge clk);
    check("rst_raddr", descrom_raddr_o, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_last", tx_last, 0);
    check("rst_tx_zlp", tx_zlp, 0);
    check("rst_req_stall", req_stall, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 1);
    rst = 1'b0;

    //          typ    idx   wlen     hs  mps    hstr dlen    blen   stall base     len     zlp retry
    vecs[0]  = '{8'h01, 8'd0, 16'd64,  0, 7'd64, 1, 16'd18, 16'd5, 0, 16'd0,   16'd18, 0, -1};
    vecs[1]  = '{8'h02, 8'd0, 16'd9,   0, 7'd64, 1, 16'd18, 16'd5, 0, 16'd28,  16'd39, 0, -1};
    vecs[2]  = '{8'h02, 8'd0, 16'hFF,  1, 7'd64, 1, 16'd18, 16'd5, 0, 16'd67,  16'd39, 0, -1};
    vecs[3]  = '{8'h07, 8'd0, 16'hFF,  1, 7'd64, 1, 16'd18, 16'd5, 0, 16'd28,  16'd39, 0, -1};
    vecs[4]  = '{8'h03, 8'd2, 16'hFF,  0, 7'd8,  1, 16'd18, 16'd5, 0, 16'd167, 16'd38, 0, 2};
    vecs[5]  = '{8'h01, 8'd0, 16'd64,  0, 7'd8,  1, 16'd16, 16'd5, 0, 16'd0,   16'd16, 1, -1};
    vecs[6]  = '{8'h01, 8'd0, 16'd16,  0, 7'd8,  1, 16'd16, 16'd5, 0, 16'd0,   16'd16, 0, -1};
    vecs[7]  = '{8'h04, 8'd0, 16'd64,  0, 7'd64, 1, 16'd18, 16'd5, 1, 16'd0,   16'd0,  0, -1};
    vecs[8]  = '{8'h03, 8'd5, 16'd64,  0, 7'd64, 1, 16'd18, 16'd5, 1, 16'd0,   16'd0,  0, -1};
    vecs[9]  = '{8'h0F, 8'd0, 16'd64,  0, 7'd64, 1, 16'd18, 16'd0, 1, 16'd0,   16'd0,  0, -1};
    vecs[10] = '{8'h03, 8'd1, 16'd64,  0, 7'd64, 0, 16'd18, 16'd5, 1, 16'd0,   16'd0,  0, -1};
    vecs[11] = '{8'h01, 8'd0, 16'd0,   0, 7'd64, 1, 16'd18, 16'd5, 0, 16'd0,   16'd18, 1, -1};
    vecs[12] = '{8'h03, 8'd0, 16'hFF,  0, 7'd8,  1, 16'd18, 16'd5, 0, 16'd156, 16'd4,  0, -1};
    vecs[13] = '{8'h22, 8'd0, 16'd48,  0, 7'd16, 1, 16'd18, 16'd5, 0, 16'd106, 16'd50, 0, -1};
    vecs[14] = '{8'h06, 8'd0, 16'd10,  1, 7'd8,  1, 16'd18, 16'd5, 0, 16'd18,  16'd10, 0, -1};
    vecs[15] = '{8'h0F, 8'd0, 16'd5,   0, 7'd32, 1, 16'd18, 16'd5, 0, 16'd300, 16'd5,  0, -1};

    for (int i = 0; i < 16; i++) begin
      dev_len = vecs[i].dlen; bos_len = vecs[i].blen; have_strings = vecs[i].have_str;
      run_xfer(vecs[i].typ, vecs[i].idx, vecs[i].wlen, vecs[i].hs, vecs[i].mps, vecs[i].exp_stall,
               vecs[i].exp_base, vecs[i].exp_len, vecs[i].exp_zlp, vecs[i].retry, 1'b0);
    end
    dev_len = 16'd18; bos_len = 16'd5; have_strings = 1'b1;

    // Abort in the middle of a packet, then a normal request.
    ep0_mps = 7'd64;
    @(negedge clk); req_valid = 1; req_type = 8'h01; req_index = 0; req_wlength = 16'd64; hs_mode = 0;
    @(negedge clk); req_valid = 0;
    @(negedge clk); in_token = 1;
    @(negedge clk); in_token = 0; tx_ready = 1;
    repeat (3) @(negedge clk);
    check("abort_pre_valid", tx_valid, 1);
    abort = 1;
    @(negedge clk); abort = 0; tx_ready = 0;
    check("abort_busy", busy, 0);
    check("abort_tx_valid", tx_valid, 0);
    check("abort_tx_last", tx_last, 0);
    check("abort_done", done, 0);
    check("abort_req_ready", req_ready, 1);
    @(negedge clk);
    check("abort_no_done_later", done, 0);
    run_xfer(8'h01, 8'd0, 16'd64, 1'b0, 7'd64, 1'b0, 16'd0, 16'd18, 1'b0, -1, 1'b0);

    // Randomized requests against the model.
    type_tab = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h06, 8'h07, 8'h0F, 8'h22};
    mps_tab  = '{7'd8, 7'd16, 7'd32, 7'd64};
    for (int n = 0; n < 40; n++) begin
      rt = type_tab[$urandom_range(0, 7)];
      ri = (rt == 8'h03) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
      rw = 16'($urandom_range(0, 90));
      rh = 1'($urandom_range(0, 1));
      rm = mps_tab[$urandom_range(0, 3)];
      dev_len = 16'($urandom_range(0, 40));
      bos_len = 16'($urandom_range(0, 12));
      rs = ($urandom_range(0, 3) != 0);
      have_strings = rs;
      model_sel(rt, ri, rh, rs, ok, rb, rl);
      nb = (rl < rw) ? rl : rw;
      rz = (nb == 16'd0) || ((rl < rw) && (nb % 16'(rm) == 16'd0));
      run_xfer(rt, ri, rw, rh, rm, !ok, rb, rl, rz,
               ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1, 1'b1);
    end
    dev_len = 16'd18; bos_len = 16'd5; have_strings = 1'b1;

    // Reset in the middle of a transfer.
    ep0_mps = 7'd8;
    @(negedge clk); req_valid = 1; req_type = 8'h02; req_index = 0; req_wlength = 16'd64; hs_mode = 1;
    @(negedge clk); req_valid = 0;
    @(negedge clk); in_token = 1;
    @(negedge clk); in_token = 0; tx_ready = 1;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("midrst_raddr", descrom_raddr_o, 0);
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_tx_last", tx_last, 0);
    check("midrst_tx_zlp", tx_zlp, 0);
    check("midrst_req_stall", req_stall, 0);
    check("midrst_done", done, 0);
    check("midrst_busy", busy, 0);
    check("midrst_req_ready", req_ready, 1);
    rst = 0; tx_ready = 0;
    run_xfer(8'h03, 8'd3, 16'd64, 1'b0, 7'd8, 1'b0, 16'd205, 16'd10, 1'b0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_desc_reader.md
Name: usb_desc_reader

Overview:
Control-endpoint-0 sequencer for GET_DESCRIPTOR data stages. It takes a decoded request, picks the descriptor's base address and length from the descriptor-table outputs, and clamps the length to wLength. It then reads the descriptor ROM one byte per cycle and splits the data into max-packet-size IN packets, with ACK/NAK retry and zero-length-packet termination. It sits between the SETUP decoder, the descriptor ROM/table block and the EP0 IN transmit path.

Parameters:
ADDR_W, 16, descriptor ROM address width and table address/length width
LEN_W, 16, wLength / transfer counter width

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  GET_DESCRIPTOR request strobe
req_ready  out  1  high only in IDLE
req_type  in  8  wValue[15:8], descriptor type
req_index  in  8  wValue[7:0], descriptor index
req_wlength  in  16  host wLength
hs_mode  in  1  1 = high-speed link
ep0_mps  in  7  EP0 max packet size (8/16/32/64)
abort  in  1  new SETUP or bus reset; cancels the transfer
desc_*_addr_i / desc_*_len_i  in  16 each  table inputs: dev, qual, fscfg, hscfg, hidrpt, bos, strvendor, strproduct, strserial; plus strlang_addr
desc_have_strings_i  in  1  string descriptors present
descrom_raddr_o  out  16  ROM read address, registered
descrom_rdata_i  in  8  ROM data, combinational from raddr
in_token  in  1  IN token received for EP0
tx_data  out  8  payload byte
tx_valid  out  1  byte valid
tx_last  out  1  last byte of current packet
tx_zlp  out  1  one-cycle request to send a zero-length packet
tx_ready  in  1  byte accepted
pkt_ack  in  1  host ACKed the last packet
pkt_retry  in  1  timeout/NAK; resend the last packet
req_stall  out  1  one-cycle pulse: unsupported request, stall EP0
busy  out  1  not IDLE
done  out  1  one-cycle pulse when the final packet is ACKed

Behaviour:
- Reset: state IDLE; descrom_raddr_o=0; tx_valid, tx_last, tx_zlp, req_stall, done, busy = 0; req_ready=1.
- States: IDLE, LOOKUP, WAIT_IN, SEND, WAIT_ACK.
- IDLE: on req_valid, capture type, index, wlength and hs_mode, then go to LOOKUP.
- LOOKUP (1 cycle): select descriptor and length.
  - type 1: dev.
  - type 2: hs_mode ? hscfg : fscfg.
  - type 6: qual.
  - type 7: hs_mode ? fscfg : hscfg.
  - type 0x0F: bos.
  - type 0x22: hidrpt.
  - type 3, have_strings=1: index 0 → strlang, length 4; index 1/2/3 → vendor/product/serial.
  - Stall cases: any other type, string index >3, have_strings=0, or selected len==0. Pulse req_stall and return to IDLE.
  - Otherwise: xfer_len = min(len, wlength); zlp_needed = (len < wlength) && xfer_len != 0 && xfer_len % ep0_mps == 0; offset=0; go to WAIT_IN.
- xfer_len==0 (wLength 0): send one ZLP on the first in_token.
- WAIT_IN: on in_token:
  - if remaining>0: pkt_start=offset, pkt_len=min(remaining, ep0_mps), go to SEND;
  - else if zlp_needed: pulse tx_zlp, go to WAIT_ACK.
- SEND:
  - descrom_raddr_o = base + offset.
  - tx_data = descrom_rdata_i, except for type 7 at offset 1, which outputs 8'h07 (other-speed config type).
  - tx_valid=1; offset advances on tx_valid && tx_ready.
  - tx_last=1 on the pkt_len-th byte of the packet; after it is accepted, go to WAIT_ACK.
  - One byte per cycle max; the address advances in the same cycle as acceptance.
- WAIT_ACK:
  - pkt_ack: remaining -= pkt_len (ZLP: clear zlp_needed). If remaining==0 and no ZLP pending, pulse done and go to IDLE; else go to WAIT_IN.
  - pkt_retry: offset = pkt_start; go to WAIT_IN (packet resent identically).
  - Both asserted together: pkt_ack wins.
- abort in any state: next cycle is IDLE, tx_valid=0, no done. abort has priority over all other inputs.
- req_valid outside IDLE is ignored.
- Arithmetic: base + offset computed mod 2^16; lengths are unsigned 16-bit.

Test Plan:
- FS, type 1, wLength 64, mps 64, dev addr 0, len 18 → one packet of 18 bytes, tx_last on byte 18, raddr 0..17, done after pkt_ack, no ZLP.
- type 2, hs_mode=0, wLength 9 → 9 bytes from fscfg addr 28; hs_mode=1, wLength 0xFF → 39 bytes from addr 67; type 7 with hs_mode=1 → 39 bytes from 28 with byte 1 = 0x07.
- type 3, index 2, len 38, mps 8 → packets of 8, 8, 8, 8, 6; a pkt_retry after packet 3 resends addresses 183..190 exactly.
- dev len driven to 16, mps 8, wLength 64 → packets 8, 8, then tx_zlp on the third in_token, done after its ack; same with wLength 16 → no ZLP.
- type 4; type 3 index 5; type 0x0F with bos_len 0; have_strings=0 with type 3 → req_stall pulse, no tx_valid, back to IDLE.
- abort mid-SEND → IDLE next cycle, tx_valid low, no done; a following request works normally; rst mid-transfer → all outputs at reset values.
